// File: rtl/nn_seq_pkg.sv
// Shared types and reset constants for the layer sequencer.
//   seq_state_t   : sequencer FSM encoding
//   SEQ_RST_STATE : state entered on reset
package nn_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        WAIT     = 3'd2,
        LYR_DONE = 3'd3,
        FINISH   = 3'd4,
        ERROR    = 3'd5
    } seq_state_t;

    localparam seq_state_t SEQ_RST_STATE = IDLE;

endpackage

// File: rtl/done_collector.sv
// Sticky per-unit completion flags for one layer.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronously clears all flags (takes priority)
//   sample_en  : enables capture of done_in into the flags
//   done_in    : per-unit done, pulse or level
//   all_set_c  : every unit is flagged or asserting done this cycle
module done_collector #(
    parameter int unsigned NUM_UNITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 sample_en,
    input  logic [NUM_UNITS-1:0] done_in,
    output logic                 all_set_c
);

    logic [NUM_UNITS-1:0] sticky;

    // Flags accumulate until explicitly cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky <= '0;
        end else if (clear) begin
            sticky <= '0;
        end else if (sample_en) begin
            sticky <= sticky | done_in;
        end
    end

    // Same-cycle dones count so the last arrival completes without a bubble
    assign all_set_c = &(sticky | done_in);

endmodule

// File: rtl/layer_sequencer.sv
// Sequences the neuron-unit bank through a multi-layer forward pass.
//   CLOCK, reset : clock, asynchronous active-high reset
//   start        : begin a pass (honoured only in IDLE or ERROR)
//   unit_done    : per-unit completion, pulse or level
//   unit_start   : one-cycle launch pulse to every unit
//   layer_idx    : current layer index
//   layer_done   : one-cycle pulse per completed layer
//   net_done     : one-cycle pulse after the last layer
//   busy         : high outside IDLE and ERROR
//   timeout_err  : a layer exceeded its cycle budget
module layer_sequencer
    import nn_seq_pkg::*;
#(
    parameter int unsigned NUM_UNITS      = 4,
    parameter int unsigned NUM_LAYERS     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned LAYER_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 CLOCK,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [LAYER_W-1:0]   layer_idx,
    output logic                 layer_done,
    output logic                 net_done,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [TO_W-1:0]    TO_LIMIT   = TO_W'(TIMEOUT_CYCLES - 1);

    seq_state_t           state;
    seq_state_t           state_nxt;
    logic [LAYER_W-1:0]   idx_nxt;
    logic [TO_W-1:0]      cnt;
    logic [TO_W-1:0]      cnt_nxt;
    logic                 flags_clear;
    logic                 flags_sample;
    logic                 all_done_c;

    done_collector #(
        .NUM_UNITS (NUM_UNITS)
    ) u_done_collector (
        .clk       (CLOCK),
        .rst       (reset),
        .clear     (flags_clear),
        .sample_en (flags_sample),
        .done_in   (unit_done),
        .all_set_c (all_done_c)
    );

    // State, counters and outputs; outputs are decoded from the next state
    // so each one is a flop aligned with the state it reflects
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            state       <= SEQ_RST_STATE;
            layer_idx   <= '0;
            cnt         <= '0;
            unit_start  <= '0;
            layer_done  <= 1'b0;
            net_done    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            layer_idx   <= idx_nxt;
            cnt         <= cnt_nxt;
            unit_start  <= {NUM_UNITS{state_nxt == LAUNCH}};
            layer_done  <= (state_nxt == LYR_DONE);
            net_done    <= (state_nxt == FINISH);
            busy        <= !((state_nxt == IDLE) || (state_nxt == ERROR));
            timeout_err <= (state_nxt == ERROR);
        end
    end

    // Next-state, layer and timeout counter logic
    always_comb begin
        state_nxt    = state;
        idx_nxt      = layer_idx;
        cnt_nxt      = cnt;
        flags_clear  = 1'b0;
        flags_sample = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LAUNCH;
                    idx_nxt   = '0;
                end
            end

            // Stale level dones from the previous layer are wiped here
            LAUNCH: begin
                flags_clear = 1'b1;
                cnt_nxt     = '0;
                state_nxt   = WAIT;
            end

            // Completion is tested before the timeout so it wins a tie
            WAIT: begin
                flags_sample = 1'b1;
                cnt_nxt      = cnt + TO_W'(1);
                if (all_done_c) begin
                    state_nxt = LYR_DONE;
                end else if (cnt == TO_LIMIT) begin
                    state_nxt = ERROR;
                end
            end

            LYR_DONE: begin
                if (layer_idx == LAST_LAYER) begin
                    state_nxt = FINISH;
                end else begin
                    idx_nxt   = layer_idx + LAYER_W'(1);
                    state_nxt = LAUNCH;
                end
            end

            FINISH: begin
                state_nxt = IDLE;
            end

            ERROR: begin
                if (start) begin
                    state_nxt = LAUNCH;
                    idx_nxt   = '0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: pulsed and level dones, timeout,
// completion/timeout tie, start while busy, async reset, single layer.
module tb_layer_sequencer;

    localparam int unsigned NU = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          start1;
    logic [NU-1:0] unit_done;

    logic [NU-1:0] us0, us1;
    logic [1:0]    idx0;
    logic [0:0]    idx1;
    logic          ld0, nd0, busy0, err0;
    logic          ld1, nd1, busy1, err1;

    always #5 clk = ~clk;

    layer_sequencer #(
        .NUM_UNITS      (NU),
        .NUM_LAYERS     (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLOCK       (clk),
        .reset       (reset),
        .start       (start),
        .unit_done   (unit_done),
        .unit_start  (us0),
        .layer_idx   (idx0),
        .layer_done  (ld0),
        .net_done    (nd0),
        .busy        (busy0),
        .timeout_err (err0)
    );

    layer_sequencer #(
        .NUM_UNITS      (NU),
        .NUM_LAYERS     (1),
        .TIMEOUT_CYCLES (16)
    ) dut1 (
        .CLOCK       (clk),
        .reset       (reset),
        .start       (start1),
        .unit_done   (unit_done),
        .unit_start  (us1),
        .layer_idx   (idx1),
        .layer_done  (ld1),
        .net_done    (nd1),
        .busy        (busy1),
        .timeout_err (err1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int t_cur    = 0;
    int sel      = 0;

    int            dly [NU];
    int            cd  [NU];
    logic [NU-1:0] mask;
    logic [NU-1:0] clr_next;
    logic          level_mode;

    int o_us, o_idx, o_ld, o_nd, o_busy, o_err;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s t=%0d: got %0d, expected %0d", tag, t_cur, got, exp);
    endtask

    task automatic capture();
        if (sel == 0) begin
            o_us = int'(us0); o_idx = int'(idx0); o_ld = int'(ld0);
            o_nd = int'(nd0); o_busy = int'(busy0); o_err = int'(err0);
        end else begin
            o_us = int'(us1); o_idx = int'(idx1); o_ld = int'(ld1);
            o_nd = int'(nd1); o_busy = int'(busy1); o_err = int'(err1);
        end
    endtask

    // Advance one cycle, sample outputs, then update the unit responders
    task automatic step();
        logic [NU-1:0] uv;
        @(posedge clk);
        #1;
        capture();
        uv = (sel == 0) ? us0 : us1;
        for (int i = 0; i < NU; i++) begin
            if (uv[i]) begin
                cd[i]       = dly[i];
                clr_next[i] = 1'b1;
                if (!level_mode) unit_done[i] = 1'b0;
            end else begin
                if (level_mode && clr_next[i]) unit_done[i] = 1'b0;
                clr_next[i] = 1'b0;
                if (!level_mode) unit_done[i] = 1'b0;
                if (cd[i] > 0) begin
                    cd[i]--;
                    if (cd[i] == 0) unit_done[i] = mask[i];
                end
            end
        end
    endtask

    // Full pass with layer period p (slowest unit delay + 2), nl layers
    task automatic check_pass(input int p, input int nl, input bit poke);
        if (sel == 0) start = 1'b1; else start1 = 1'b1;
        step();
        start  = 1'b0;
        start1 = 1'b0;
        for (int t = 1; t <= nl * p + 3; t++) begin
            if (t > 1) step();
            t_cur = t;
            check("unit_start", o_us, (((t - 1) % p == 0) && ((t - 1) / p < nl)) ? 15 : 0);
            check("layer_done", o_ld, ((t % p == 0) && (t / p <= nl)) ? 1 : 0);
            check("layer_idx", o_idx, ((t - 1) / p < nl - 1) ? (t - 1) / p : nl - 1);
            check("net_done", o_nd, (t == nl * p + 1) ? 1 : 0);
            check("busy", o_busy, (t <= nl * p + 1) ? 1 : 0);
            check("timeout_err", o_err, 0);
            start = (poke && (t == 3 || t == p + 2)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic quiet_units();
        for (int i = 0; i < NU; i++) cd[i] = 0;
        clr_next  = '0;
        unit_done = '0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        start1     = 1'b0;
        mask       = '1;
        level_mode = 1'b0;
        dly        = '{5, 7, 3, 9};
        quiet_units();

        // Reset state
        #1;
        t_cur = 0;
        capture();
        check("rst_unit_start", o_us, 0);
        check("rst_layer_idx", o_idx, 0);
        check("rst_layer_done", o_ld, 0);
        check("rst_net_done", o_nd, 0);
        check("rst_busy", o_busy, 0);
        check("rst_timeout_err", o_err, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // Pulsed dones 5/7/3/9, with start poked while busy
        check_pass(11, 3, 1'b1);
        step();

        // Held level dones all arriving together
        level_mode = 1'b1;
        dly        = '{4, 4, 4, 4};
        check_pass(6, 3, 1'b0);
        level_mode = 1'b0;
        quiet_units();
        step();

        // Unit 2 silent: timeout after 16 WAIT cycles
        dly   = '{5, 7, 3, 9};
        mask  = 4'b1011;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            if (t > 1) step();
            t_cur = t;
            check("to_timeout_err", o_err, (t >= 18) ? 1 : 0);
            check("to_busy", o_busy, (t <= 17) ? 1 : 0);
            check("to_layer_done", o_ld, 0);
            check("to_layer_idx", o_idx, 0);
        end

        // Restart from ERROR clears the flag and begins at layer 0
        mask = '1;
        check_pass(11, 3, 1'b0);
        step();

        // Last done lands on the final timeout cycle: completion wins
        dly = '{3, 3, 16, 3};
        check_pass(18, 3, 1'b0);
        step();

        // Asynchronous reset during layer 1 WAIT
        dly   = '{5, 7, 3, 9};
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 2; t <= 14; t++) step();
        t_cur = 14;
        check("mid_layer_idx", o_idx, 1);
        check("mid_busy", o_busy, 1);
        #2;
        reset = 1'b1;
        #1;
        capture();
        check("arst_unit_start", o_us, 0);
        check("arst_layer_idx", o_idx, 0);
        check("arst_layer_done", o_ld, 0);
        check("arst_net_done", o_nd, 0);
        check("arst_busy", o_busy, 0);
        check("arst_timeout_err", o_err, 0);
        quiet_units();
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            step();
            t_cur = t;
            check("post_rst_busy", o_busy, 0);
            check("post_rst_unit_start", o_us, 0);
            check("post_rst_layer_idx", o_idx, 0);
        end

        // Single-layer instance
        sel = 1;
        check_pass(11, 1, 1'b0);
        sel = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
